// File: rtl/tow_pkg.sv
// Shared types and helpers for the tug-of-war engine.
package tow_pkg;

  typedef enum logic [1:0] {
    StPlay,
    StPoint,
    StOver
  } tow_state_e;

  // One-hot vector with bit `pos` set; zero when pos is outside an n-light bar.
  function automatic logic [31:0] onehot_pos(input int unsigned pos, input int unsigned n);
    logic [31:0] r;
    r = '0;
    if (pos < n && pos < 32) r[pos] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw button -> synchroniser -> rising-edge detect -> registered one-cycle press pulse.
module btn_conditioner #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int unsigned CntW = $clog2(SYNC_STAGES + 2);
  // Detection opens only once the sync chain and the edge flop hold real samples,
  // so a button held through reset release never looks like a fresh edge.
  localparam logic [CntW-1:0] EnCnt = CntW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   press_q, press_d;
  logic                   sync_out;
  logic                   det_en;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign det_en   = (cnt_q == EnCnt);

  // Next-state: shift chain, track history, count up to enable, detect edge.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
    prev_d  = sync_out;
    cnt_d   = det_en ? cnt_q : cnt_q + 1'b1;
    press_d = det_en && sync_out && !prev_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/tug_of_war_core.sv
// Tug-of-war engine: light position, point scoring and match-over latch.
module tug_of_war_core
  import tow_pkg::*;
#(
  parameter int unsigned N_LIGHTS    = 9,
  parameter int unsigned SCORE_W     = 3,
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_l,
  input  logic                btn_r,
  output logic [N_LIGHTS-1:0] lights,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r,
  output logic                point_l,
  output logic                point_r,
  output logic                match_over,
  output logic                winner_l
);

  localparam int unsigned PosW = $clog2(N_LIGHTS);
  localparam int unsigned CtrI = (N_LIGHTS - 1) / 2;
  localparam logic [PosW-1:0] Ctr    = PosW'(CtrI);
  localparam logic [PosW-1:0] PosMax = PosW'(N_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);
  localparam logic [N_LIGHTS-1:0] LeftHalf  = ~((N_LIGHTS'(1) << CtrI) - N_LIGHTS'(1));
  localparam logic [N_LIGHTS-1:0] RightHalf = (N_LIGHTS'(1) << (CtrI + 1)) - N_LIGHTS'(1);
  localparam logic [N_LIGHTS-1:0] CtrLight  = N_LIGHTS'(1) << CtrI;

  logic press_l, press_r;

  btn_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_cond_l (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_l),
    .press(press_l)
  );

  btn_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_cond_r (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_r),
    .press(press_r)
  );

  tow_state_e              state_q, state_d;
  logic [PosW-1:0]         pos_q, pos_d;
  logic [SCORE_W-1:0]      score_l_q, score_l_d, score_r_q, score_r_d;
  logic                    point_l_q, point_l_d, point_r_q, point_r_d;
  logic                    match_q, match_d, winner_q, winner_d;
  logic [N_LIGHTS-1:0]     lights_q, lights_d;

  // Next-state: game FSM, position, scores, then lights derived from the next state.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    point_l_d = 1'b0;
    point_r_d = 1'b0;
    match_d   = match_q;
    winner_d  = winner_q;
    lights_d  = '0;

    unique case (state_q)
      StPlay: begin
        if (press_l && !press_r) begin
          if (pos_q == PosMax) begin
            state_d   = StPoint;
            point_l_d = 1'b1;
            score_l_d = (score_l_q == ScoreMax) ? score_l_q : score_l_q + 1'b1;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else if (press_r && !press_l) begin
          if (pos_q == '0) begin
            state_d   = StPoint;
            point_r_d = 1'b1;
            score_r_d = (score_r_q == ScoreMax) ? score_r_q : score_r_q + 1'b1;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
      StPoint: begin
        // Only the player who just scored can have newly reached the target.
        if (score_l_q == WinScore || score_r_q == WinScore) begin
          state_d  = StOver;
          match_d  = 1'b1;
          winner_d = (score_l_q == WinScore);
        end else begin
          state_d = StPlay;
          pos_d   = Ctr;
        end
      end
      StOver: ;
      default: state_d = StPlay;
    endcase

    unique case (state_d)
      StPlay:  lights_d = N_LIGHTS'(1) << pos_d;
      StPoint: lights_d = '0;
      StOver:  lights_d = winner_d ? LeftHalf : RightHalf;
      default: lights_d = '0;
    endcase
  end

  // State and registered outputs with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StPlay;
      pos_q     <= Ctr;
      score_l_q <= '0;
      score_r_q <= '0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
      match_q   <= 1'b0;
      winner_q  <= 1'b0;
      lights_q  <= CtrLight;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      point_l_q <= point_l_d;
      point_r_q <= point_r_d;
      match_q   <= match_d;
      winner_q  <= winner_d;
      lights_q  <= lights_d;
    end
  end

  assign lights     = lights_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign point_l    = point_l_q;
  assign point_r    = point_r_q;
  assign match_over = match_q;
  assign winner_l   = winner_q;

endmodule

// File: tb/tb_tug_of_war_core.sv
// Directed self-checking bench for tug_of_war_core (default parameters).
module tb_tug_of_war_core;
  import tow_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_l, btn_r;
  logic [8:0] lights;
  logic [2:0] score_l, score_r;
  logic       point_l, point_r, match_over, winner_l;

  int checks   = 0;
  int failures = 0;
  int pl_cnt   = 0;
  int pr_cnt   = 0;

  tug_of_war_core #(
    .N_LIGHTS   (9),
    .SCORE_W    (3),
    .WIN_SCORE  (7),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .lights    (lights),
    .score_l   (score_l),
    .score_r   (score_r),
    .point_l   (point_l),
    .point_r   (point_r),
    .match_over(match_over),
    .winner_l  (winner_l)
  );

  always #5 clk = ~clk;

  // Count point pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (point_l === 1'b1) pl_cnt++;
    if (point_r === 1'b1) pr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(10);
  endtask

  // One-cycle raw press, then enough idle for the move (or point) to land.
  task automatic press_once(input logic left);
    if (left) btn_l = 1'b1; else btn_r = 1'b1;
    tick(1);
    btn_l = 1'b0;
    btn_r = 1'b0;
    tick(6);
  endtask

  task automatic test_reset();
    int pl0, pr0;
    btn_l = 1'b0;
    btn_r = 1'b0;
    reset = 1'b0;
    tick(3);
    checks++; if (lights !== 9'b000010000) begin failures++; $display("FAIL reset_lights got=%b exp=%b", lights, 9'b000010000); end
    checks++; if (score_l !== 3'd0 || score_r !== 3'd0) begin failures++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", score_l, score_r); end
    checks++; if (match_over !== 1'b0 || winner_l !== 1'b0) begin failures++; $display("FAIL reset_match got=%b%b exp=00", match_over, winner_l); end
    reset = 1'b1;
    pl0 = pl_cnt;
    pr0 = pr_cnt;
    tick(10);
    checks++; if (lights !== 9'b000010000) begin failures++; $display("FAIL idle_lights got=%b exp=%b", lights, 9'b000010000); end
    checks++; if (pl_cnt != pl0 || pr_cnt != pr0) begin failures++; $display("FAIL idle_points got=%0d/%0d exp=0/0", pl_cnt - pl0, pr_cnt - pr0); end
  endtask

  task automatic test_hold();
    btn_l = 1'b1;
    tick(3);
    checks++; if (lights !== 9'b000010000) begin failures++; $display("FAIL hold_early got=%b exp=%b", lights, 9'b000010000); end
    tick(1);
    checks++; if (lights !== 9'b000100000) begin failures++; $display("FAIL hold_latency got=%b exp=%b", lights, 9'b000100000); end
    tick(16);
    checks++; if (lights !== 9'b000100000) begin failures++; $display("FAIL hold_single got=%b exp=%b", lights, 9'b000100000); end
    btn_l = 1'b0;
    tick(5);
  endtask

  task automatic test_score_left();
    logic [31:0] oh;
    int pl0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      press_once(1'b1);
      oh = onehot_pos(5 + i, 9);
      checks++; if (lights !== oh[8:0]) begin failures++; $display("FAIL climb_%0d got=%b exp=%b", i, lights, oh[8:0]); end
    end
    pl0 = pl_cnt;
    btn_l = 1'b1;
    tick(1);
    btn_l = 1'b0;
    tick(3);
    checks++; if (point_l !== 1'b1 || lights !== 9'b0) begin failures++; $display("FAIL point_cycle got=%b/%b exp=1/%b", point_l, lights, 9'b0); end
    checks++; if (score_l !== 3'd1 || score_r !== 3'd0) begin failures++; $display("FAIL point_score got=%0d/%0d exp=1/0", score_l, score_r); end
    tick(1);
    checks++; if (point_l !== 1'b0 || lights !== 9'b000010000) begin failures++; $display("FAIL recentre got=%b/%b exp=0/%b", point_l, lights, 9'b000010000); end
    tick(4);
    checks++; if (pl_cnt - pl0 != 1) begin failures++; $display("FAIL point_pulses got=%0d exp=1", pl_cnt - pl0); end
  endtask

  task automatic test_simultaneous();
    int pl0, pr0;
    pl0 = pl_cnt;
    pr0 = pr_cnt;
    btn_l = 1'b1;
    btn_r = 1'b1;
    tick(1);
    btn_l = 1'b0;
    btn_r = 1'b0;
    tick(8);
    checks++; if (lights !== 9'b000010000) begin failures++; $display("FAIL simul_lights got=%b exp=%b", lights, 9'b000010000); end
    checks++; if (pl_cnt != pl0 || pr_cnt != pr0) begin failures++; $display("FAIL simul_points got=%0d/%0d exp=0/0", pl_cnt - pl0, pr_cnt - pr0); end
  endtask

  task automatic test_right_wins();
    int pr0;
    apply_reset();
    pr0 = pr_cnt;
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < 5; k++) press_once(1'b0);
      if (p == 5) begin
        checks++; if (score_r !== 3'd6 || match_over !== 1'b0) begin failures++; $display("FAIL six_points got=%0d/%b exp=6/0", score_r, match_over); end
      end
    end
    checks++; if (match_over !== 1'b1 || winner_l !== 1'b0) begin failures++; $display("FAIL right_win got=%b%b exp=10", match_over, winner_l); end
    checks++; if (lights !== 9'b000011111) begin failures++; $display("FAIL over_lights got=%b exp=%b", lights, 9'b000011111); end
    checks++; if (score_r !== 3'd7 || score_l !== 3'd0) begin failures++; $display("FAIL final_scores got=%0d/%0d exp=0/7", score_l, score_r); end
    checks++; if (pr_cnt - pr0 != 7) begin failures++; $display("FAIL right_pulses got=%0d exp=7", pr_cnt - pr0); end
    for (int k = 0; k < 3; k++) begin
      press_once(1'b1);
      press_once(1'b0);
    end
    checks++; if (lights !== 9'b000011111 || match_over !== 1'b1) begin failures++; $display("FAIL over_frozen got=%b/%b exp=%b/1", lights, match_over, 9'b000011111); end
    checks++; if (score_r !== 3'd7 || score_l !== 3'd0) begin failures++; $display("FAIL over_scores got=%0d/%0d exp=0/7", score_l, score_r); end
  endtask

  task automatic test_reset_recovery();
    // Asynchronous reset from OVER, with left held across release.
    #3;
    btn_l = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (lights !== 9'b000010000 || match_over !== 1'b0 || winner_l !== 1'b0) begin failures++; $display("FAIL over_reset got=%b/%b%b exp=%b/00", lights, match_over, winner_l, 9'b000010000); end
    checks++; if (score_r !== 3'd0 || score_l !== 3'd0) begin failures++; $display("FAIL over_reset_scores got=%0d/%0d exp=0/0", score_l, score_r); end
    tick(2);
    reset = 1'b1;
    tick(15);
    checks++; if (lights !== 9'b000010000) begin failures++; $display("FAIL held_release got=%b exp=%b", lights, 9'b000010000); end
    btn_l = 1'b0;
    tick(5);
    // Mid-round reset.
    press_once(1'b1);
    press_once(1'b1);
    checks++; if (lights !== 9'b001000000) begin failures++; $display("FAIL midround_pos got=%b exp=%b", lights, 9'b001000000); end
    btn_l = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    checks++; if (lights !== 9'b000010000) begin failures++; $display("FAIL midround_reset got=%b exp=%b", lights, 9'b000010000); end
    tick(2);
    reset = 1'b1;
    tick(15);
    checks++; if (lights !== 9'b000010000) begin failures++; $display("FAIL mid_held_release got=%b exp=%b", lights, 9'b000010000); end
    btn_l = 1'b0;
    tick(5);
    press_once(1'b0);
    checks++; if (lights !== 9'b000001000) begin failures++; $display("FAIL post_reset_press got=%b exp=%b", lights, 9'b000001000); end
  endtask

  initial begin
    reset = 1'b0;
    btn_l = 1'b0;
    btn_r = 1'b0;
    test_reset();
    test_hold();
    test_score_left();
    test_simultaneous();
    test_right_wins();
    test_reset_recovery();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tug_of_war_core.md
Name: tug_of_war_core

Overview:
Parametrised tug-of-war game engine with a configurable light count and multi-round match scoring. Two raw player buttons are synchronised and edge-detected inside the block, and a single position register drives a one-hot light bar. When a player pushes the light off their end, that player scores a point and the light re-centres. The first player to reach WIN_SCORE wins the match, and the block then freezes. It replaces the per-LED light chain and the separate input/victory blocks at the board top level.

Parameters:
N_LIGHTS, 9, number of lights in the bar; must be odd and >= 3; centre index CTR = (N_LIGHTS-1)/2
SCORE_W, 3, width of each score counter
WIN_SCORE, 7, points needed to win the match; must be 1..2^SCORE_W-1
SYNC_STAGES, 2, flip-flop depth of each button synchroniser; must be >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn_l  in  1  raw left-player button, active-high, asynchronous to clk
btn_r  in  1  raw right-player button, active-high, asynchronous to clk
lights  out  N_LIGHTS  light bar; bit N_LIGHTS-1 is the leftmost light
score_l  out  SCORE_W  left player's point count
score_r  out  SCORE_W  right player's point count
point_l  out  1  one-cycle pulse when the left player scores
point_r  out  1  one-cycle pulse when the right player scores
match_over  out  1  high once either player reaches WIN_SCORE
winner_l  out  1  valid when match_over is high; 1 = left won, 0 = right won

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - pos=CTR; lights=one-hot(CTR); scores=0; point_l/r=0; match_over=0; winner_l=0; state=PLAY.
  - Synchroniser and edge-detect flops clear to 0.
- Input conditioning:
  - Each button passes through SYNC_STAGES flops, then a rising-edge detect.
  - press_x is a one-cycle pulse; a held button gives exactly one pulse.
  - Latency from a raw edge to the press_x pulse is SYNC_STAGES+1 clk cycles.
- States: PLAY, POINT, OVER.
- PLAY:
  - press_l only: if pos==N_LIGHTS-1, go to POINT and credit left; otherwise pos++.
  - press_r only: if pos==0, go to POINT and credit right; otherwise pos--.
  - press_l and press_r in the same cycle cancel; no change.
  - Position updates take effect on the clock edge after the press pulse.
- Entering POINT:
  - The scorer's score increments (saturating at 2^SCORE_W-1).
  - The matching point_x is high for exactly that one cycle.
  - lights=0 while in POINT.
- POINT, after exactly 1 cycle:
  - If the new score == WIN_SCORE, go to OVER: match_over=1, winner_l set.
  - Otherwise pos=CTR and go to PLAY.
  - Presses arriving while in POINT are discarded.
- OVER:
  - lights = all ones on the winner's half, inclusive of CTR: bits [N_LIGHTS-1:CTR] for left, [CTR:0] for right.
  - All presses are ignored; scores hold.
  - Only reset exits OVER.
- lights is registered (a function of pos/state), never combinational from the buttons.
- Reset mid-round or in OVER returns the block to the reset values immediately, regardless of button state.
- A button held through reset release does not generate a press.
  - Edge-detect history clears to 0, but the sync chain must fill first; the edge flop is loaded from the sync output before detection is enabled.
  - Detection is enabled SYNC_STAGES+1 cycles after release.

Decomposition:
- Package tow_pkg: state enum (PLAY, POINT, OVER) and a function onehot_pos(pos, N) for use by the bench.
- Sub-module btn_conditioner (parameter SYNC_STAGES): ports clk, reset, raw, press.
  - Contains the synchroniser, edge detect and post-reset enable counter.
  - Instantiated twice.
- The core FSM, position counter and score counters stay in tug_of_war_core.

Test Plan:
- Reset, then idle 10 cycles -> lights=9'b000010000, scores 0/0, match_over=0, no point pulses.
- btn_l held 20 cycles -> exactly one step: lights=9'b000100000, appearing SYNC_STAGES+2 cycles after the raw edge.
- 5 separate btn_l presses from centre -> pos climbs 5,6,7,8; the 5th press gives point_l=1 for one cycle and score_l=1; next cycle lights=9'b000010000.
- btn_l and btn_r rising in the same cycle -> no movement; lights stay centred.
- Right player scores 7 points with WIN_SCORE=7 -> match_over=1, winner_l=0, lights=9'b000011111; further presses change nothing.
- Async reset pulse in OVER and mid-round with btn_l held across release -> outputs return to reset values at once; no press is recorded after release.
